dmem_arbiter: RTL and testbench

//  Shares the single tagged data-memory port between two requesters: port 0 = load/store

---
 rtl/sys_defs.sv | 25 ++
 rtl/mem_tag_table.sv | 71 +++++++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared bus/memory definitions for the data-memory path.
package sys_defs;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned NUM_MEM_TAGS = 15;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } DMEM_ARB_STATE;

endpackage

// File: rtl/mem_tag_table.sv
// Tag ownership table: records which requester issued each outstanding load tag,
// and keeps a per-requester count of outstanding loads.
module mem_tag_table
  import sys_defs::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned NUM_TAGS = NUM_MEM_TAGS,
  parameter int unsigned MAX_OUT  = 4,
  localparam int unsigned TAG_W   = $clog2(NUM_TAGS + 1),
  localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            alloc_en,
  input  logic [TAG_W-1:0]                alloc_tag,
  input  logic                            alloc_owner,
  input  logic [TAG_W-1:0]                free_tag,
  output logic                            free_hit,
  output logic                            free_owner,
  output logic [NUM_REQ-1:0][CNT_W-1:0]   out_cnt
);

  logic [NUM_TAGS-1:0] valid;
  logic [NUM_TAGS-1:0] owner;
  logic [TAG_W-1:0]    alloc_idx;
  logic [TAG_W-1:0]    free_idx;
  logic [NUM_REQ-1:0]  inc;
  logic [NUM_REQ-1:0]  dec;

  // Tag 0 means "no tag", so entry k holds tag k+1.
  assign alloc_idx = alloc_tag - TAG_W'(1);
  assign free_idx  = free_tag - TAG_W'(1);

  always_comb begin
    free_hit   = 1'b0;
    free_owner = 1'b0;
    if (free_tag != '0) begin
      free_hit   = valid[free_idx];
      free_owner = owner[free_idx];
    end
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inc[i] = alloc_en && (alloc_owner == 1'(i));
      dec[i] = free_hit && (free_owner == 1'(i));
    end
  end

  // Allocation is written after the free so a same-cycle reuse leaves the entry valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid   <= '0;
      owner   <= '0;
      out_cnt <= '0;
    end else begin
      if (free_hit) valid[free_idx] <= 1'b0;
      if (alloc_en) begin
        valid[alloc_idx] <= 1'b1;
        owner[alloc_idx] <= alloc_owner;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (inc[i] && !dec[i])      out_cnt[i] <= out_cnt[i] + CNT_W'(1);
        else if (dec[i] && !inc[i]) out_cnt[i] <= out_cnt[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the tagged data-memory port between the LSU (port 0)
// and instruction fetch (port 1), routing returned load data back to its issuer.
module dmem_arbiter
  import sys_defs::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned NUM_TAGS = NUM_MEM_TAGS,
  parameter int unsigned MAX_OUT  = 4,
  parameter int unsigned DATA_W   = 64
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*2-1:0]      req_cmd,
  input  logic [NUM_REQ*XLEN-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_size,
  output logic [NUM_REQ-1:0]        req_accept,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [1:0]                proc2mem_command,
  output logic [XLEN-1:0]           proc2mem_addr,
  output logic [DATA_W-1:0]         proc2mem_data,
  output logic [1:0]                proc2mem_size,
  input  logic [3:0]                mem2proc_response,
  input  logic [DATA_W-1:0]         mem2proc_data,
  input  logic [3:0]                mem2proc_tag,
  output logic                      err_orphan_tag
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  DMEM_ARB_STATE                  state;
  logic                           rr_ptr;
  logic                           hold_id;
  logic                           grant;
  logic                           drive;
  logic                           active;
  logic                           accepted;
  logic                           alloc_en;
  logic                           free_hit;
  logic                           free_owner;
  logic [1:0]                     g_cmd;
  logic [NUM_REQ-1:0]             elig;
  logic [NUM_REQ-1:0][CNT_W-1:0]  out_cnt;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] &&
                !((req_cmd[i*2 +: 2] == BUS_LOAD) && (out_cnt[i] == CNT_W'(MAX_OUT)));
  end

  // A held (rejected) request owns the bus regardless of eligibility or pointer.
  always_comb begin
    grant = rr_ptr;
    drive = 1'b0;
    if (state == HOLD) begin
      grant = hold_id;
      drive = 1'b1;
    end else if (elig[rr_ptr]) begin
      grant = rr_ptr;
      drive = 1'b1;
    end else if (elig[~rr_ptr]) begin
      grant = ~rr_ptr;
      drive = 1'b1;
    end
  end

  assign active   = drive && reset_n;
  assign g_cmd    = grant ? req_cmd[3:2] : req_cmd[1:0];
  assign accepted = active && (mem2proc_response != '0);
  assign alloc_en = accepted && (g_cmd == BUS_LOAD);

  assign proc2mem_command = active ? g_cmd : BUS_NONE;
  assign proc2mem_addr    = grant ? req_addr[XLEN +: XLEN]     : req_addr[0 +: XLEN];
  assign proc2mem_data    = grant ? req_data[DATA_W +: DATA_W] : req_data[0 +: DATA_W];
  assign proc2mem_size    = grant ? req_size[3:2]              : req_size[1:0];
  assign req_accept       = accepted ? (NUM_REQ'(1) << grant) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ARB;
      rr_ptr  <= 1'b0;
      hold_id <= 1'b0;
    end else if (accepted) begin
      rr_ptr <= ~grant;
      state  <= ARB;
    end else if (active) begin
      hold_id <= grant;
      state   <= HOLD;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid      <= '0;
      rsp_data       <= '0;
      err_orphan_tag <= 1'b0;
    end else begin
      rsp_valid      <= free_hit ? (NUM_REQ'(1) << free_owner) : '0;
      err_orphan_tag <= (mem2proc_tag != '0) && !free_hit;
      if (free_hit) rsp_data <= mem2proc_data;
    end
  end

  mem_tag_table #(
    .NUM_REQ  (NUM_REQ),
    .NUM_TAGS (NUM_TAGS),
    .MAX_OUT  (MAX_OUT)
  ) u_tag_table (
    .clock       (clock),
    .reset_n     (reset_n),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_response),
    .alloc_owner (grant),
    .free_tag    (mem2proc_tag),
    .free_hit    (free_hit),
    .free_owner  (free_owner),
    .out_cnt     (out_cnt)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of requesters, tags and memory.
module tb_dmem_arbiter;
  import sys_defs::*;

  localparam int unsigned MAXO = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   req_valid;
  logic [3:0]   req_cmd;
  logic [63:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_size;
  logic [1:0]   req_accept;
  logic [1:0]   rsp_valid;
  logic [63:0]  rsp_data;
  logic [1:0]   proc2mem_command;
  logic [31:0]  proc2mem_addr;
  logic [63:0]  proc2mem_data;
  logic [1:0]   proc2mem_size;
  logic [3:0]   mem2proc_response;
  logic [63:0]  mem2proc_data;
  logic [3:0]   mem2proc_tag;
  logic         err_orphan_tag;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .NUM_REQ  (2),
    .NUM_TAGS (15),
    .MAX_OUT  (4),
    .DATA_W   (64)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_cmd           (req_cmd),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .req_size          (req_size),
    .req_accept        (req_accept),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .proc2mem_size     (proc2mem_size),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .err_orphan_tag    (err_orphan_tag)
  );

  // Stimulus as seen by each requester and by memory.
  logic        v [2];
  logic [1:0]  c [2];
  logic [31:0] a [2];
  logic [63:0] d [2];
  logic [1:0]  s [2];
  logic [3:0]  resp;
  logic [3:0]  rtag;
  logic [63:0] rdata;

  // Behavioural model: who holds the bus, who is preferred next, who owns each tag.
  bit          m_held;
  int          m_held_id;
  int          m_next;
  bit          m_tv [16];
  int          m_to [16];
  int          m_cnt [2];
  logic [1:0]  e_rsp_valid;
  logic [63:0] e_rsp_data;
  bit          e_err;
  logic [1:0]  e_acc;

  // Memory side: tags the memory believes are outstanding loads.
  bit          mem_busy [16];

  logic [1:0]  cap_acc;
  logic [1:0]  cap_cmd;
  logic [31:0] cap_addr;
  logic [1:0]  cap_rsp_valid;
  logic [63:0] cap_rsp_data;
  logic        cap_err;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_req(input int i, input logic vv, input logic [1:0] cc,
                         input logic [31:0] aa, input logic [63:0] dd, input logic [1:0] ss);
    v[i] = vv; c[i] = cc; a[i] = aa; d[i] = dd; s[i] = ss;
  endtask

  task automatic idle_mem();
    resp = '0; rtag = '0; rdata = '0;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < 2; i++) begin
      req_valid[i]        = v[i];
      req_cmd[i*2 +: 2]   = c[i];
      req_addr[i*32 +: 32] = a[i];
      req_data[i*64 +: 64] = d[i];
      req_size[i*2 +: 2]  = s[i];
    end
    mem2proc_response = resp;
    mem2proc_tag      = rtag;
    mem2proc_data     = rdata;
  endtask

  function automatic void model_clear();
    m_held = 0; m_held_id = 0; m_next = 0;
    for (int t = 0; t < 16; t++) begin m_tv[t] = 0; m_to[t] = 0; end
    m_cnt[0] = 0; m_cnt[1] = 0;
    e_rsp_valid = '0; e_rsp_data = '0; e_err = 0; e_acc = '0;
  endfunction

  // Who gets the bus this cycle, from the arbitration rules.
  function automatic void model_grant(output bit drv, output int g);
    bit ok [2];
    for (int i = 0; i < 2; i++)
      ok[i] = v[i] && !(c[i] == BUS_LOAD && m_cnt[i] >= MAXO);
    drv = 0; g = 0;
    if (m_held) begin
      drv = 1; g = m_held_id;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int i;
        i = (m_next + k) % 2;
        if (!drv && ok[i]) begin drv = 1; g = i; end
      end
    end
  endfunction

  // One clock: called at a falling edge with stimulus set, returns at the next one.
  task automatic cycle();
    bit drv;
    int g;
    logic [1:0] ecmd;
    apply_inputs();
    model_grant(drv, g);
    ecmd  = drv ? c[g] : BUS_NONE;
    e_acc = (drv && resp != 0) ? 2'(1 << g) : 2'b00;
    #1;
    cap_acc = req_accept; cap_cmd = proc2mem_command; cap_addr = proc2mem_addr;
    chk("command", proc2mem_command, ecmd);
    chk("accept", req_accept, e_acc);
    if (drv) begin
      chk("addr", proc2mem_addr, a[g]);
      chk("data", proc2mem_data, d[g]);
      chk("size", proc2mem_size, s[g]);
    end
    @(posedge clock);
    e_rsp_valid = '0;
    e_err = 0;
    if (rtag != 0) begin
      if (m_tv[rtag]) begin
        e_rsp_valid = 2'(1 << m_to[rtag]);
        e_rsp_data  = rdata;
        m_tv[rtag]  = 0;
        m_cnt[m_to[rtag]]--;
      end else begin
        e_err = 1;
      end
    end
    if (e_acc != 0) begin
      if (c[g] == BUS_LOAD) begin
        m_tv[resp] = 1; m_to[resp] = g; m_cnt[g]++;
      end
      m_next = 1 - g;
      m_held = 0;
    end else if (drv) begin
      m_held = 1; m_held_id = g;
    end
    #1;
    cap_rsp_valid = rsp_valid; cap_rsp_data = rsp_data; cap_err = err_orphan_tag;
    chk("rsp_valid", rsp_valid, e_rsp_valid);
    chk("rsp_data", rsp_data, e_rsp_data);
    chk("err_orphan", err_orphan_tag, e_err);
    @(negedge clock);
  endtask

  // Asserted between edges, so the clear must happen without a clock.
  task automatic do_reset();
    reset_n = 1'b0;
    resp = '0; rtag = '0;
    apply_inputs();
    #1;
    chk("rst_command", proc2mem_command, BUS_NONE);
    chk("rst_accept", req_accept, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk("rst_err", err_orphan_tag, 1'b0);
    model_clear();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin : main
    int q [$];
    bit drv;
    int g;
    int pulses;

    for (int i = 0; i < 2; i++) set_req(i, 0, BUS_NONE, '0, '0, '0);
    for (int t = 0; t < 16; t++) mem_busy[t] = 0;
    idle_mem();
    apply_inputs();
    @(negedge clock);

    // Single load, tag 3 returns five cycles after issue.
    set_req(0, 1, BUS_LOAD, 32'h100, 64'h0, WORD);
    do_reset();
    resp = 4'd3;
    cycle();
    chk("t1_accept", cap_acc, 2'b01);
    v[0] = 0; idle_mem();
    for (int k = 0; k < 4; k++) cycle();
    rtag = 4'd3; rdata = 64'hDEAD;
    cycle();
    chk("t1_rsp_valid", cap_rsp_valid, 2'b01);
    chk("t1_rsp_data", cap_rsp_data, 64'hDEAD);
    idle_mem();

    // Both ports loading every cycle, memory always accepting.
    do_reset();
    set_req(0, 1, BUS_LOAD, 32'h200, 64'h0, DOUBLE);
    set_req(1, 1, BUS_LOAD, 32'h1000, 64'h0, WORD);
    for (int k = 0; k < 4; k++) begin
      resp = 4'(k + 1);
      cycle();
      chk("t2_alternate", cap_acc, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle_mem();

    // Port 1 rejected three times while port 0 waits.
    do_reset();
    set_req(0, 0, BUS_LOAD, 32'h200, 64'h0, WORD);
    set_req(1, 1, BUS_LOAD, 32'h300, 64'h0, WORD);
    resp = 4'd0;
    cycle();
    chk("t3_reject", cap_acc, 2'b00);
    v[0] = 1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("t3_hold_addr", cap_addr, 32'h300);
    end
    resp = 4'd5;
    cycle();
    chk("t3_accept1", cap_acc, 2'b10);
    v[1] = 0; resp = 4'd6;
    cycle();
    chk("t3_accept0", cap_acc, 2'b01);
    idle_mem();

    // Port 0 fills its outstanding-load budget.
    do_reset();
    set_req(0, 1, BUS_LOAD, 32'h400, 64'h0, WORD);
    set_req(1, 0, BUS_LOAD, 32'h500, 64'h0, WORD);
    for (int k = 1; k <= 4; k++) begin
      resp = 4'(k);
      cycle();
      chk("t4_fill", cap_acc, 2'b01);
    end
    resp = 4'd0;
    cycle();
    chk("t4_blocked", cap_cmd, BUS_NONE);
    v[1] = 1; resp = 4'd5;
    cycle();
    chk("t4_port1_a", cap_acc, 2'b10);
    resp = 4'd6;
    cycle();
    chk("t4_port1_b", cap_acc, 2'b10);
    v[1] = 0; resp = 4'd0; rtag = 4'd1; rdata = 64'h11;
    cycle();
    chk("t4_still_blocked", cap_cmd, BUS_NONE);
    chk("t4_return", cap_rsp_valid, 2'b01);
    idle_mem(); resp = 4'd7;
    cycle();
    chk("t4_unblocked", cap_acc, 2'b01);
    idle_mem();

    // Tag 2 returns in the cycle it is reallocated to port 1.
    do_reset();
    set_req(0, 1, BUS_LOAD, 32'h600, 64'h0, WORD);
    set_req(1, 0, BUS_LOAD, 32'h700, 64'h0, WORD);
    resp = 4'd2;
    cycle();
    v[0] = 0; v[1] = 1; resp = 4'd2; rtag = 4'd2; rdata = 64'h1234;
    cycle();
    chk("t5_accept", cap_acc, 2'b10);
    chk("t5_old_owner", cap_rsp_valid, 2'b01);
    chk("t5_data", cap_rsp_data, 64'h1234);
    chk("t5_model_owner", 128'(m_to[2]), 128'd1);
    v[1] = 0; idle_mem(); rtag = 4'd2; rdata = 64'h5678;
    cycle();
    chk("t5_new_owner", cap_rsp_valid, 2'b10);
    chk("t5_new_data", cap_rsp_data, 64'h5678);
    idle_mem();

    // Reset with two loads outstanding forgets them.
    do_reset();
    set_req(0, 1, BUS_LOAD, 32'h800, 64'h0, WORD);
    set_req(1, 0, BUS_LOAD, 32'h900, 64'h0, WORD);
    resp = 4'd7;
    cycle();
    v[0] = 0; v[1] = 1; resp = 4'd8;
    cycle();
    v[1] = 0; idle_mem();
    cycle();
    do_reset();
    cycle();
    pulses = 0;
    rtag = 4'd7; rdata = 64'hAA;
    cycle();
    pulses += int'(cap_err);
    chk("t6_no_rsp7", cap_rsp_valid, 2'b00);
    rtag = 4'd8; rdata = 64'hBB;
    cycle();
    pulses += int'(cap_err);
    chk("t6_no_rsp8", cap_rsp_valid, 2'b00);
    idle_mem();
    cycle();
    pulses += int'(cap_err);
    chk("t6_pulses", 128'(pulses), 128'd2);

    // Randomized traffic.
    do_reset();
    for (int t = 0; t < 16; t++) mem_busy[t] = 0;
    for (int i = 0; i < 2; i++) v[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++)
        if (!v[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1, ($urandom_range(0, 9) < 7) ? BUS_LOAD : BUS_STORE, $urandom,
                  {$urandom, $urandom}, 2'($urandom_range(0, 3)));
      rtag = '0;
      rdata = {$urandom, $urandom};
      q.delete();
      for (int t = 1; t < 16; t++) if (mem_busy[t]) q.push_back(t);
      if (q.size() > 0 && $urandom_range(0, 3) == 0) begin
        rtag = 4'(q[$urandom_range(0, q.size() - 1)]);
        mem_busy[rtag] = 0;
      end else if ($urandom_range(0, 49) == 0) begin
        q.delete();
        for (int t = 1; t < 16; t++) if (!mem_busy[t]) q.push_back(t);
        if (q.size() > 0) rtag = 4'(q[$urandom_range(0, q.size() - 1)]);
      end
      model_grant(drv, g);
      resp = '0;
      if (drv && $urandom_range(0, 9) < 7) begin
        if (rtag != 0 && $urandom_range(0, 2) == 0) begin
          resp = rtag;
        end else begin
          q.delete();
          for (int t = 1; t < 16; t++) if (!mem_busy[t]) q.push_back(t);
          if (q.size() > 0) resp = 4'(q[$urandom_range(0, q.size() - 1)]);
        end
        if (resp != 0 && c[g] == BUS_LOAD) mem_busy[resp] = 1;
      end
      cycle();
      for (int i = 0; i < 2; i++) if (e_acc[i]) v[i] = 0;
      if ($urandom_range(0, 699) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
